mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, the maximum consecutive dmem grants while imem waits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports imem_addr input 32, imem_rmask input 4, imem_rdata output 32, imem_resp output 1: fetch requester.
REQ-005 The block SHALL have ports dmem_addr input 32, dmem_rmask input 4, dmem_wmask input 4, dmem_wdata input 32, dmem_rdata output 32, dmem_resp output 1: data requester.
REQ-006 The block SHALL have ports mem_addr output 32, mem_rmask output 4, mem_wmask output 4, mem_wdata output 32: shared memory request.
REQ-007 The block SHALL have ports mem_rdata input 32, mem_resp input 1: shared memory response.

Function
REQ-008 A requester SHALL be pending when any bit of its rmask (or, for dmem, wmask) is nonzero; the requester holds its request stable until it sees its resp.
REQ-009 FSM states SHALL be IDLE, IMEM_BUSY, DMEM_BUSY.
REQ-010 In IDLE with no pending requester, the block SHALL stay in IDLE and drive mem_rmask=mem_wmask=0.
REQ-011 In IDLE with exactly one requester pending, the block SHALL latch that request (addr, masks, wdata) into internal registers and move to that requester's BUSY state next cycle.
REQ-012 In IDLE with both pending, dmem SHALL win unless the starvation counter equals STARVE_LIMIT, in which case imem SHALL win.
REQ-013 Starvation counter SHALL increment (saturating at STARVE_LIMIT) on each dmem grant made while imem is pending, and clear to 0 on every imem grant.
REQ-014 In a BUSY state, mem_addr/mem_rmask/mem_wmask/mem_wdata SHALL be driven from the latched registers; the imem latch SHALL drive mem_wmask=0.
REQ-015 In a BUSY state, when mem_resp=1, the owner's resp SHALL be 1 in that same cycle, its rdata SHALL equal mem_rdata combinationally, and state SHALL return to IDLE next cycle.
REQ-016 The non-owner resp SHALL be 0 in all cycles; both resp outputs SHALL be 0 in IDLE.
REQ-017 imem_rdata/dmem_rdata SHALL equal mem_rdata whenever the corresponding resp is 1; the value is don't-care otherwise.
REQ-018 mem_resp received in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-019 Requester inputs changing during BUSY SHALL NOT affect the downstream request.
REQ-020 Minimum latency: request in cycle T, downstream request in T+1, resp no earlier than T+1; one IDLE cycle separates consecutive grants.
REQ-021 dmem requests with both rmask and wmask nonzero SHALL be forwarded unchanged (no checking).

Reset
REQ-022 While rst=1, state SHALL become IDLE, starvation counter 0, latched masks 0, so next cycle mem_rmask=mem_wmask=0 and imem_resp=dmem_resp=0.
REQ-023 Reset asserted mid-transaction SHALL abandon it silently; a late mem_resp after reset falls under REQ-018.
REQ-024 mem_addr and mem_wdata values after reset SHALL be don't-care while the masks are 0.

Verification
REQ-025 imem only: imem_addr=0x1eceb000, rmask=0xF at cycle 0; mem_resp=1, mem_rdata=0x00000013 at cycle 2 -> mem_addr=0x1eceb000, mem_rmask=0xF at cycles 1-2; imem_resp=1, imem_rdata=0x00000013 at cycle 2; mem_rmask=0 at cycle 3.
REQ-026 Simultaneous: imem rmask=0xF, dmem wmask=0x3 addr=0x1eceb100 wdata=0xDEADBEEF at cycle 0 -> dmem granted first (mem_wmask=0x3, mem_rmask=0); after its resp, imem is granted following one IDLE cycle.
REQ-027 Starvation: imem held pending, dmem re-requests immediately after every resp, STARVE_LIMIT=4 -> exactly 4 dmem grants, then the imem grant, then the counter is 0.
REQ-028 Reset mid-op: dmem granted, rst=1 before mem_resp; mem_resp=1 one cycle after rst deasserts -> no dmem_resp pulse; masks 0; a new imem request is granted normally.
REQ-029 Stray response: mem_resp=1 in IDLE with no requests -> both resp=0, state stays IDLE.
REQ-030 Input stability: change dmem_addr during DMEM_BUSY -> mem_addr keeps the latched value until the resp cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data access normally wins ties. A starvation counter eventually forces an instruction fetch grant.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IMEM_BUSY = 2'd1,
        DMEM_BUSY = 2'd2
    } state_e;

    state_e        state_r, state_s;
    logic [CW-1:0] starve_r, starve_s;
    logic [31:0]   addr_r, addr_s;
    logic [31:0]   wdata_r, wdata_s;
    logic [3:0]    rmask_r, rmask_s;
    logic [3:0]    wmask_r, wmask_s;
    logic          imem_pend_s;
    logic          dmem_pend_s;

    assign imem_pend_s = |imem_rmask;
    assign dmem_pend_s = (|dmem_rmask) | (|dmem_wmask);

    // Next-state, grant selection and request latching.
    always_comb begin
        state_s  = state_r;
        starve_s = starve_r;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        rmask_s  = rmask_r;
        wmask_s  = wmask_r;
        case (state_r)
            IDLE: begin
                // Once imem has waited through LIMIT data grants it takes the next slot.
                if (dmem_pend_s && (!imem_pend_s || (starve_r != LIMIT))) begin
                    state_s = DMEM_BUSY;
                    addr_s  = dmem_addr;
                    wdata_s = dmem_wdata;
                    rmask_s = dmem_rmask;
                    wmask_s = dmem_wmask;
                    if (imem_pend_s) begin
                        starve_s = starve_r + CW'(1);
                    end else begin
                        starve_s = starve_r;
                    end
                end else if (imem_pend_s) begin
                    state_s  = IMEM_BUSY;
                    addr_s   = imem_addr;
                    wdata_s  = 32'h0000_0000;
                    rmask_s  = imem_rmask;
                    wmask_s  = 4'h0;
                    starve_s = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            IMEM_BUSY, DMEM_BUSY: begin
                // Masks are cleared on completion so the port is quiet in IDLE.
                if (mem_resp) begin
                    state_s = IDLE;
                    rmask_s = 4'h0;
                    wmask_s = 4'h0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
                rmask_s = 4'h0;
                wmask_s = 4'h0;
            end
        endcase
    end

    // State, starvation counter and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            starve_r <= {CW{1'b0}};
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            rmask_r  <= 4'h0;
            wmask_r  <= 4'h0;
        end else begin
            state_r  <= state_s;
            starve_r <= starve_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            rmask_r  <= rmask_s;
            wmask_r  <= wmask_s;
        end
    end

    assign mem_addr  = addr_r;
    assign mem_rmask = rmask_r;
    assign mem_wmask = wmask_r;
    assign mem_wdata = wdata_r;

    // Responses pass straight through to the current owner in the same cycle.
    assign imem_resp  = (state_r == IMEM_BUSY) & mem_resp;
    assign dmem_resp  = (state_r == DMEM_BUSY) & mem_resp;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the grant rules.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        mem_resp;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the port (0 none, 1 imem, 2 dmem), the granted request, starvation count.
    int          m_owner;
    int          m_cnt;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_rmask, m_wmask;
    logic        last_i, last_d;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        imem_addr = 32'h0; imem_rmask = 4'h0;
        dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
        mem_rdata = 32'h0; mem_resp = 1'b0;
    endtask

    // Compare DUT outputs with the model for the current cycle.
    task automatic cyc_check();
        #1;
        last_i = (m_owner == 1) && mem_resp;
        last_d = (m_owner == 2) && mem_resp;
        chk("imem_resp", 32'(imem_resp), 32'(last_i));
        chk("dmem_resp", 32'(dmem_resp), 32'(last_d));
        if (m_owner == 0) begin
            chk("idle_rmask", 32'(mem_rmask), 32'h0);
            chk("idle_wmask", 32'(mem_wmask), 32'h0);
        end else begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_rmask", 32'(mem_rmask), 32'(m_rmask));
            chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (last_i) chk("imem_rdata", imem_rdata, mem_rdata);
        if (last_d) chk("dmem_rdata", dmem_rdata, mem_rdata);
    endtask

    // Apply the grant rules to the inputs seen at this clock edge.
    task automatic cyc_adv();
        bit ip, dp;
        ip = (imem_rmask != 4'h0);
        dp = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
        if (rst) begin
            m_owner = 0;
            m_cnt   = 0;
        end else if (m_owner == 0) begin
            if (dp && (!ip || m_cnt < LIM)) begin
                m_owner = 2;
                m_addr  = dmem_addr; m_wdata = dmem_wdata;
                m_rmask = dmem_rmask; m_wmask = dmem_wmask;
                if (ip) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
            end else if (ip) begin
                m_owner = 1;
                m_addr  = imem_addr; m_rmask = imem_rmask; m_wmask = 4'h0;
                m_cnt   = 0;
            end
        end else if (mem_resp) begin
            m_owner = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc_check();
        cyc_adv();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit i_act, d_act;
        int phase, nd1, nd2;
        logic [3:0] rm;

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_owner = 0; m_cnt = 0; m_addr = 32'h0; m_wdata = 32'h0; m_rmask = 4'h0; m_wmask = 4'h0;
        cyc_check();
        chk("reset_rmask", 32'(mem_rmask), 32'h0);
        chk("reset_wmask", 32'(mem_wmask), 32'h0);
        chk("reset_iresp", 32'(imem_resp), 32'h0);
        chk("reset_dresp", 32'(dmem_resp), 32'h0);
        cyc_adv();
        rst = 1'b0;

        // imem only, response in cycle 2
        imem_addr = 32'h1eceb000; imem_rmask = 4'hF;
        step();
        cyc_check();
        chk("i_only_addr_c1", mem_addr, 32'h1eceb000);
        chk("i_only_rmask_c1", 32'(mem_rmask), 32'hF);
        cyc_adv();
        mem_resp = 1'b1; mem_rdata = 32'h00000013;
        cyc_check();
        chk("i_only_addr_c2", mem_addr, 32'h1eceb000);
        chk("i_only_resp_c2", 32'(imem_resp), 32'h1);
        chk("i_only_rdata_c2", imem_rdata, 32'h00000013);
        cyc_adv();
        clear_inputs();
        cyc_check();
        chk("i_only_rmask_c3", 32'(mem_rmask), 32'h0);
        cyc_adv();

        // simultaneous requests: dmem first, imem after one IDLE cycle
        do_reset();
        imem_addr = 32'h1eceb000; imem_rmask = 4'hF;
        dmem_addr = 32'h1eceb100; dmem_wmask = 4'h3; dmem_wdata = 32'hDEADBEEF;
        step();
        mem_resp = 1'b1;
        cyc_check();
        chk("sim_wmask", 32'(mem_wmask), 32'h3);
        chk("sim_rmask", 32'(mem_rmask), 32'h0);
        chk("sim_addr", mem_addr, 32'h1eceb100);
        chk("sim_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sim_dresp", 32'(dmem_resp), 32'h1);
        cyc_adv();
        dmem_wmask = 4'h0; mem_resp = 1'b0;
        cyc_check();
        chk("sim_gap_rmask", 32'(mem_rmask), 32'h0);
        cyc_adv();
        cyc_check();
        chk("sim_i_rmask", 32'(mem_rmask), 32'hF);
        chk("sim_i_addr", mem_addr, 32'h1eceb000);
        cyc_adv();
        mem_resp = 1'b1;
        step();

        // starvation: both held pending, memory always answers
        do_reset();
        imem_addr = 32'h00001000; imem_rmask = 4'hF;
        dmem_addr = 32'h00002000; dmem_wmask = 4'h1; dmem_wdata = 32'h12345678;
        mem_resp = 1'b1;
        phase = 0; nd1 = 0; nd2 = 0;
        for (int k = 0; k < 60 && phase < 2; k++) begin
            cyc_check();
            if (dmem_resp) begin
                if (phase == 0) nd1++; else nd2++;
            end
            if (imem_resp) begin
                phase++;
                if (phase == 1) chk("starve_model_cnt", 32'(m_cnt), 32'h0);
            end
            cyc_adv();
        end
        chk("starve_round1", 32'(nd1), 32'd4);
        chk("starve_round2", 32'(nd2), 32'd4);
        chk("starve_done", 32'(phase), 32'd2);

        // reset mid-transaction, then a late response in IDLE
        do_reset();
        dmem_addr = 32'h00003000; dmem_rmask = 4'hF;
        step();
        rst = 1'b1; dmem_rmask = 4'h0;
        step();
        rst = 1'b0;
        cyc_check();
        chk("rst_mid_rmask", 32'(mem_rmask), 32'h0);
        cyc_adv();
        mem_resp = 1'b1;
        cyc_check();
        chk("late_resp_d", 32'(dmem_resp), 32'h0);
        chk("late_resp_i", 32'(imem_resp), 32'h0);
        cyc_adv();
        mem_resp = 1'b0; imem_addr = 32'h00004000; imem_rmask = 4'h3;
        step();
        cyc_check();
        chk("post_rst_i_rmask", 32'(mem_rmask), 32'h3);
        chk("post_rst_i_addr", mem_addr, 32'h00004000);
        cyc_adv();
        mem_resp = 1'b1;
        step();
        clear_inputs();
        step();

        // input stability while dmem owns the port
        dmem_addr = 32'h00005000; dmem_rmask = 4'h1;
        step();
        dmem_addr = 32'h0000BAD0;
        step();
        mem_resp = 1'b1;
        cyc_check();
        chk("stable_addr", mem_addr, 32'h00005000);
        cyc_adv();
        clear_inputs();
        step();

        // random traffic
        i_act = 1'b0; d_act = 1'b0; last_i = 1'b0; last_d = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (last_i) i_act = 1'b0;
            if (last_d) d_act = 1'b0;
            if (!i_act && $urandom_range(2, 0) == 0) begin
                i_act = 1'b1;
                imem_addr  = $urandom;
                imem_rmask = 4'($urandom_range(15, 1));
            end
            if (!i_act) imem_rmask = 4'h0;
            if (!d_act && $urandom_range(2, 0) == 0) begin
                d_act = 1'b1;
                dmem_addr  = $urandom;
                dmem_wdata = $urandom;
                rm = 4'($urandom_range(15, 0));
                dmem_rmask = rm;
                dmem_wmask = (rm == 4'h0) ? 4'($urandom_range(15, 1)) : 4'($urandom_range(15, 0));
            end
            if (!d_act) begin
                dmem_rmask = 4'h0;
                dmem_wmask = 4'h0;
            end
            if (m_owner == 2 && $urandom_range(3, 0) == 0) begin
                dmem_addr  = $urandom;
                dmem_wdata = $urandom;
            end
            if (m_owner == 1 && $urandom_range(3, 0) == 0) imem_addr = $urandom;
            mem_resp  = ($urandom_range(2, 0) == 0);
            mem_rdata = $urandom;
            rst       = ($urandom_range(149, 0) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
